// File: rtl/clk_probe_unit.sv
// ---------------------------------------------------------------------------
// clk_probe_unit
//
// Behavioural, synthesizable stand-in for the board clock-wizard plus the
// virtual-I/O debug pair that wraps the processor core. Everything lives in
// the single w_clk domain; the "divided clock" is a registered level plus a
// one-cycle enable strobe, so downstream logic should qualify on w_clk_en
// rather than clocking on w_clk_out.
//
// Ports
//   w_clk        in   board clock, all logic on its rising edge
//   w_reset      in   asynchronous, active-high reset
//   w_clk_out    out  divided clock (period 2*DIV_HALF w_clk cycles, 50% duty)
//   w_locked     out  divided clock valid; set LOCK_CYCLES edges after reset
//   w_clk_en     out  one-cycle strobe on each rising edge of w_clk_out
//   w_probe_in   in   monitored bus
//   w_freeze     in   1 = hold the captured value, no capture
//   w_probe_q    out  last captured probe value
//   w_probe_par  out  bit i = XOR of byte i of w_probe_q
//   w_change     out  1 for one capture when the sample differs from the last
//   w_wr         in   write strobe for the output probe
//   w_wdata      in   write data for the output probe
//   w_probe_out  out  host-driven output probe register
//
// Strobe semantics: w_clk_en is the only qualifier in this block. A capture
// happens on the w_clk edge where w_clk_en (as registered on the previous
// edge) is 1 and w_freeze is 0; there is no back-pressure.
// ---------------------------------------------------------------------------
module clk_probe_unit #(
    parameter int unsigned       DIV_HALF       = 1,
    parameter int unsigned       LOCK_CYCLES    = 16,
    parameter int unsigned       WIDTH          = 32,
    parameter logic [WIDTH-1:0]  PROBE_OUT_INIT = '0
) (
    input  logic                 w_clk,
    input  logic                 w_reset,
    output logic                 w_clk_out,
    output logic                 w_locked,
    output logic                 w_clk_en,
    input  logic [WIDTH-1:0]     w_probe_in,
    input  logic                 w_freeze,
    output logic [WIDTH-1:0]     w_probe_q,
    output logic [WIDTH/8-1:0]   w_probe_par,
    output logic                 w_change,
    input  logic                 w_wr,
    input  logic [WIDTH-1:0]     w_wdata,
    output logic [WIDTH-1:0]     w_probe_out
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned DIV_W  = $clog2(DIV_HALF + 1);

    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_HALF - 1);

    logic [LOCK_W-1:0]  lock_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic               capture;
    logic [NBYTES-1:0]  par_next;

    // ------------------------------------------------------------------
    // Lock: count edges after reset release; the counter freezes once
    // locked, so it never needs to wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge w_clk or posedge w_reset) begin
        if (w_reset) begin
            lock_cnt <= '0;
            w_locked <= 1'b0;
        end else if (!w_locked) begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
            if (lock_cnt == LOCK_LAST) begin
                w_locked <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Divider: held idle with w_clk_out low until locked. The enable is
    // raised on the same edge that w_clk_out goes 0->1, i.e. when the
    // terminal count is reached while the output is currently low.
    // ------------------------------------------------------------------
    always_ff @(posedge w_clk or posedge w_reset) begin
        if (w_reset) begin
            div_cnt   <= '0;
            w_clk_out <= 1'b0;
            w_clk_en  <= 1'b0;
        end else if (!w_locked) begin
            div_cnt   <= '0;
            w_clk_out <= 1'b0;
            w_clk_en  <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            w_clk_out <= ~w_clk_out;
            w_clk_en  <= ~w_clk_out;
        end else begin
            div_cnt   <= div_cnt + DIV_W'(1);
            w_clk_en  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Probe capture with per-byte parity of the incoming sample.
    // ------------------------------------------------------------------
    assign capture = w_clk_en & ~w_freeze;

    always_comb begin
        par_next = '0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            par_next[i] = ^w_probe_in[8*i +: 8];
        end
    end

    always_ff @(posedge w_clk or posedge w_reset) begin
        if (w_reset) begin
            w_probe_q   <= '0;
            w_probe_par <= '0;
            w_change    <= 1'b0;
        end else if (capture) begin
            w_probe_q   <= w_probe_in;
            w_probe_par <= par_next;
            w_change    <= (w_probe_in != w_probe_q);
        end else begin
            w_change    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Host output probe: only the write strobe touches it, regardless of
    // lock or freeze state.
    // ------------------------------------------------------------------
    always_ff @(posedge w_clk or posedge w_reset) begin
        if (w_reset) begin
            w_probe_out <= PROBE_OUT_INIT;
        end else if (w_wr) begin
            w_probe_out <= w_wdata;
        end
    end

endmodule

// File: tb/tb_clk_probe_unit.sv
// ---------------------------------------------------------------------------
// tb_clk_probe_unit
//
// Two instances share one set of inputs: instance a uses DIV_HALF=1 /
// LOCK_CYCLES=16, instance b uses DIV_HALF=3 / LOCK_CYCLES=5 with a non-zero
// output-probe reset value. A reference model derives every output from the
// number of edges seen since reset release; the driver pushes one expected
// record per edge and a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_clk_probe_unit;

    localparam int W  = 32;
    localparam int NB = W / 8;

    localparam int          D_A    = 1;
    localparam int          L_A    = 16;
    localparam logic [W-1:0] INIT_A = 32'h0000_0000;
    localparam int          D_B    = 3;
    localparam int          L_B    = 5;
    localparam logic [W-1:0] INIT_B = 32'hA5A5_0F0F;

    typedef struct packed {
        logic          locked;
        logic          clk_out;
        logic          clk_en;
        logic [W-1:0]  q;
        logic [NB-1:0] par;
        logic          change;
        logic [W-1:0]  pout;
    } obs_t;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          w_reset = 1'b1;
    logic          w_freeze = 1'b0;
    logic          w_wr = 1'b0;
    logic [W-1:0]  w_probe_in = '0;
    logic [W-1:0]  w_wdata = '0;

    always #5 clk = ~clk;

    logic          a_clk_out, a_locked, a_clk_en, a_change;
    logic [W-1:0]  a_q, a_pout;
    logic [NB-1:0] a_par;
    logic          b_clk_out, b_locked, b_clk_en, b_change;
    logic [W-1:0]  b_q, b_pout;
    logic [NB-1:0] b_par;

    clk_probe_unit #(
        .DIV_HALF(D_A), .LOCK_CYCLES(L_A), .WIDTH(W), .PROBE_OUT_INIT(INIT_A)
    ) u_a (
        .w_clk(clk), .w_reset(w_reset), .w_clk_out(a_clk_out),
        .w_locked(a_locked), .w_clk_en(a_clk_en), .w_probe_in(w_probe_in),
        .w_freeze(w_freeze), .w_probe_q(a_q), .w_probe_par(a_par),
        .w_change(a_change), .w_wr(w_wr), .w_wdata(w_wdata),
        .w_probe_out(a_pout)
    );

    clk_probe_unit #(
        .DIV_HALF(D_B), .LOCK_CYCLES(L_B), .WIDTH(W), .PROBE_OUT_INIT(INIT_B)
    ) u_b (
        .w_clk(clk), .w_reset(w_reset), .w_clk_out(b_clk_out),
        .w_locked(b_locked), .w_clk_en(b_clk_en), .w_probe_in(w_probe_in),
        .w_freeze(w_freeze), .w_probe_q(b_q), .w_probe_par(b_par),
        .w_change(b_change), .w_wr(w_wr), .w_wdata(w_wdata),
        .w_probe_out(b_pout)
    );

    obs_t act_a, act_b;
    assign act_a = {a_locked, a_clk_out, a_clk_en, a_q, a_par, a_change, a_pout};
    assign act_b = {b_locked, b_clk_out, b_clk_en, b_q, b_par, b_change, b_pout};

    // ---------------- scoreboard ----------------
    obs_t exp_a[$];
    obs_t exp_b[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_obs(input string tag, input obs_t act, input obs_t exp);
        check({tag, ".locked"},  W'(act.locked),  W'(exp.locked));
        check({tag, ".clk_out"}, W'(act.clk_out), W'(exp.clk_out));
        check({tag, ".clk_en"},  W'(act.clk_en),  W'(exp.clk_en));
        check({tag, ".probe_q"}, act.q,           exp.q);
        check({tag, ".par"},     W'(act.par),     W'(exp.par));
        check({tag, ".change"},  W'(act.change),  W'(exp.change));
        check({tag, ".probe_out"}, act.pout,      exp.pout);
    endtask

    // ---------------- reference model ----------------
    int   m_n[2];
    obs_t m_s[2];

    function automatic obs_t reset_obs(input logic [W-1:0] init);
        obs_t o;
        o      = '0;
        o.pout = init;
        return o;
    endfunction

    function automatic logic [NB-1:0] parity_of(input logic [W-1:0] v);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++) begin
            p[b] = ($countones(v[8*b +: 8]) % 2) == 1;
        end
        return p;
    endfunction

    // One rising edge of w_clk for instance k, using the inputs present
    // just before the edge. n = edges since reset release.
    task automatic model_edge(input int k, input int d, input int l,
                              input logic [W-1:0] init);
        obs_t s;
        bit   cap;
        int   m;
        s = m_s[k];
        if (w_reset) begin
            m_n[k] = 0;
            s      = reset_obs(init);
        end else begin
            cap      = s.clk_en && !w_freeze;
            s.change = cap && (w_probe_in != s.q);
            if (cap) begin
                s.q   = w_probe_in;
                s.par = parity_of(w_probe_in);
            end
            if (w_wr) s.pout = w_wdata;
            m_n[k]++;
            m         = m_n[k] - l;
            s.locked  = (m >= 0);
            s.clk_out = (m >= 0) && (((m / d) % 2) == 1);
            s.clk_en  = (m > 0) && ((m % d) == 0) && (((m / d) % 2) == 1);
        end
        m_s[k] = s;
    endtask

    // ---------------- driver ----------------
    task automatic cycle();
        @(posedge clk);
        model_edge(0, D_A, L_A, INIT_A);
        model_edge(1, D_B, L_B, INIT_B);
        exp_a.push_back(m_s[0]);
        exp_b.push_back(m_s[1]);
        #1;
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) != 0) w_probe_in = $urandom();
            w_freeze = ($urandom_range(0, 3) == 0);
            w_wr     = ($urandom_range(0, 4) == 0);
            w_wdata  = $urandom();
            cycle();
        end
    endtask

    // ---------------- monitor ----------------
    always begin
        obs_t e;
        @(negedge clk);
        if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            compare_obs("a", act_a, e);
        end
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            compare_obs("b", act_b, e);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        m_n[0] = 0;
        m_n[1] = 0;
        m_s[0] = reset_obs(INIT_A);
        m_s[1] = reset_obs(INIT_B);

        repeat (3) cycle();

        // Release, then write the output probe while still unlocked.
        w_reset = 1'b0;
        w_wr    = 1'b1;
        w_wdata = 32'hDEAD_BEEF;
        cycle();
        w_wr    = 1'b0;
        w_wdata = 32'h1234_5678;
        repeat (3) cycle();

        // Capture and parity through lock.
        w_probe_in = 32'h0103_0700;
        repeat (30) cycle();

        // Freeze behaviour.
        w_probe_in = 32'h0000_000F;
        repeat (14) cycle();
        w_freeze   = 1'b1;
        w_probe_in = 32'hFFFF_FFFF;
        repeat (14) cycle();
        w_freeze   = 1'b0;
        repeat (14) cycle();

        random_cycles(400);

        // Asynchronous reset between edges while locked.
        cycle();
        w_reset = 1'b1;
        #1;
        compare_obs("a_async_rst", act_a, reset_obs(INIT_A));
        compare_obs("b_async_rst", act_b, reset_obs(INIT_B));
        m_n[0] = 0;
        m_n[1] = 0;
        m_s[0] = reset_obs(INIT_A);
        m_s[1] = reset_obs(INIT_B);
        exp_a[exp_a.size() - 1] = m_s[0];
        exp_b[exp_b.size() - 1] = m_s[1];
        repeat (2) cycle();
        w_reset = 1'b0;
        w_freeze = 1'b0;
        w_wr     = 1'b0;
        repeat (20) cycle();
        random_cycles(60);

        @(negedge clk);
        #1;
        check("queue_drain", W'(exp_a.size() + exp_b.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_probe_unit.md
Name: clk_probe_unit

Overview:
- Behavioural, synthesizable stand-in for the board-level clock-wizard and virtual-I/O debug pair that wraps the processor core.
- Derives a divided, lock-qualified clock from the board clock.
- Samples a 32-bit debug bus on that clock's rising edges and reports its byte parities.
- Provides a host-writable output probe register.
- Everything runs in the single input clock domain; the divided clock is a registered output.

Parameters:
- DIV_HALF, 1: w_clk cycles per half-period of w_clk_out; output period = 2*DIV_HALF cycles; legal range >= 1.
- LOCK_CYCLES, 16: w_clk rising edges after reset release until lock; legal range >= 1.
- WIDTH, 32: probe width; must be a multiple of 8.
- PROBE_OUT_INIT, 0: reset value of w_probe_out.

Ports:
- w_clk  in  1  board clock; all logic on rising edge.
- w_reset  in  1  asynchronous, active-high reset.
- w_clk_out  out  1  divided clock, registered.
- w_locked  out  1  divided clock valid.
- w_clk_en  out  1  one-cycle pulse marking each rising edge of w_clk_out.
- w_probe_in  in  WIDTH  monitored bus (processor LED/result word).
- w_freeze  in  1  1 = hold the captured value.
- w_probe_q  out  WIDTH  last captured probe value.
- w_probe_par  out  WIDTH/8  bit i = XOR of byte i of w_probe_q.
- w_change  out  1  1 for one capture when the new sample differs from the previous one.
- w_wr  in  1  write strobe for the output probe.
- w_wdata  in  WIDTH  write data.
- w_probe_out  out  WIDTH  host-driven output probe.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - lock counter = 0, divider counter = 0.
  - w_clk_out = 0, w_locked = 0, w_clk_en = 0.
  - w_probe_q = 0, w_probe_par = 0, w_change = 0.
  - w_probe_out = PROBE_OUT_INIT.
- Lock:
  - The lock counter increments on each w_clk edge while w_locked = 0.
  - w_locked registers 1 on the LOCK_CYCLES-th edge after reset release.
  - w_locked stays 1 until the next reset.
- Divider:
  - Inactive while w_locked = 0, with w_clk_out held at 0.
  - Once locked, the counter counts 0..DIV_HALF-1.
  - On the edge where the counter equals DIV_HALF-1: toggle w_clk_out and clear the counter.
  - The first toggle is a rise, occurring DIV_HALF edges after w_locked rises.
  - Duty cycle is exactly 50%.
- Clock enable:
  - w_clk_en is registered 1 on exactly the edge where w_clk_out goes 0->1, and is 0 on the following edge unless another rise occurs.
  - With DIV_HALF = 1, w_clk_en is high every other cycle.
  - w_clk_en is never 1 while unlocked.
- Capture, on an edge where w_clk_en = 1 and w_freeze = 0:
  - w_probe_q <= w_probe_in.
  - w_probe_par[i] <= ^w_probe_in[8i+7:8i].
  - w_change <= (w_probe_in != w_probe_q).
- Capture, on other edges:
  - w_change <= 0; w_probe_q and w_probe_par hold.
  - w_freeze = 1 blocks capture and forces w_change to 0.
- Output probe:
  - w_wr = 1: w_probe_out <= w_wdata on that edge.
  - Independent of lock and freeze.
  - No other source modifies it.
- Simultaneous events:
  - Reset overrides all.
  - Write and capture in the same cycle are independent.
- Widths: all counters are sized to hold their parameter value; no wrap occurs before terminal count.

Test Plan:
- Lock timing: LOCK_CYCLES = 16, DIV_HALF = 1; release reset before edge 1 -> w_locked = 0 through edge 15 and 1 after edge 16; w_clk_out rises on edge 17; w_clk_en = 1 only after edges 17, 19, 21, ...
- Capture and parity: locked; w_probe_in = 32'h01030700 held -> after the first capture, w_probe_q = 32'h01030700, w_probe_par = 4'b1010 (bytes 01, 03, 07, 00 -> 1, 0, 1, 0), w_change = 1 for one cycle; a repeated identical value gives w_change = 0.
- Freeze: capture 32'h0000000F, then set w_freeze = 1 and change the input to 32'hFFFFFFFF -> w_probe_q remains 32'h0000000F and w_change stays 0; clear w_freeze -> the next capture gives 32'hFFFFFFFF, w_probe_par = 4'b0000, w_change = 1.
- Divider ratio: DIV_HALF = 3 -> w_clk_out period is 6 w_clk cycles, high for 3; w_clk_en is high for 1 of every 6 cycles, coincident with each rise.
- Output probe: w_wr = 1 with w_wdata = 32'hDEADBEEF while unlocked -> w_probe_out = 32'hDEADBEEF on the next edge; w_wr = 0 -> value holds.
- Reset mid-operation: assert w_reset between edges while locked -> w_locked, w_clk_out, w_probe_q and w_probe_par go to 0 and w_probe_out to PROBE_OUT_INIT immediately, without waiting for an edge; the full lock sequence repeats after release.
